// File: rtl/kiwi_pio_pkg.sv
// kiwi_pio_pkg: shared types and widths for the Kiwi PIO arbiter slice.
//   arb_state_t  - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   PIO_AW/DW    - shim address / data widths
//   CNT_W        - read-latency counter width (RD_LAT up to 15)
//   STAT_*_W     - statistics counter widths (KIWI_PIO_ARB_STATS_EN builds)
package kiwi_pio_pkg;

  localparam int PIO_AW      = 8;
  localparam int PIO_DW      = 32;
  localparam int CNT_W       = 4;
  localparam int STAT_TXN_W  = 32;
  localparam int STAT_CONF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/kiwi_rr_arbiter.sv
// kiwi_rr_arbiter: combinational round-robin pick.
// Selects the first set bit of req at or after ptr, wrapping N-1 -> 0.
//   req  in  N   request vector
//   ptr  in  IW  search start position (must be < N)
//   gnt  out N   one-hot grant (all zero when no request)
//   idx  out IW  binary index of the granted bit
//   any  out 1   at least one request present
module kiwi_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/kiwi_pio_arbiter.sv
// kiwi_pio_arbiter: shares the director-shim PIO port between NREQ requesters.
// One transaction at a time, round-robin fairness, fixed shim read latency.
// Optional macro KIWI_PIO_ARB_STATS_EN adds stat_txns / stat_conflicts.
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/write [NREQ]    per-requester request, 1 = write
//   req_addr  [NREQ*8]        slice i = [8i+7:8i]
//   req_wdata [NREQ*32]       slice i = [32i+31:32i]
//   req_ready [NREQ]          one-hot accept pulse (combinational in IDLE)
//   rsp_valid [NREQ]          one-hot completion pulse
//   rsp_rdata [32]            last captured read data
//   pio_addr/pio_wdata/pio_hwen/pio_rdata   shim port
//   stat_txns [32]            RESP cycles, wrapping (stats builds)
//   stat_conflicts [16]       IDLE cycles with >=2 requests, saturating (stats builds)
module kiwi_pio_arbiter
  import kiwi_pio_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*PIO_AW-1:0]   req_addr,
  input  logic [NREQ*PIO_DW-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [PIO_DW-1:0]        rsp_rdata,
  output logic [PIO_AW-1:0]        pio_addr,
  output logic [PIO_DW-1:0]        pio_wdata,
  output logic                     pio_hwen,
  input  logic [PIO_DW-1:0]        pio_rdata
`ifdef KIWI_PIO_ARB_STATS_EN
  ,
  output logic [STAT_TXN_W-1:0]    stat_txns,
  output logic [STAT_CONF_W-1:0]   stat_conflicts
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

  arb_state_t       state, state_next;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    g_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gidx;
  logic             any;
  logic             capture;

  kiwi_rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // WAIT lasts RD_LAT-1 cycles, so pio_rdata is captured on the edge that
  // ends WAIT when the counter is about to reach zero; with RD_LAT = 1 there
  // is no WAIT and the capture happens at the end of ISSUE.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    pio_hwen   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = gnt;
        if (any) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        pio_hwen = write_q;
        if (write_q) begin
          state_next = ST_RESP;
        end else if (LAT_M1 == '0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[g_q] = 1'b1;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // pio_addr/pio_wdata are loaded only at accept, so they show the new
  // transaction from ISSUE onward and hold it until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      g_q       <= '0;
      write_q   <= 1'b0;
      cnt       <= '0;
      pio_addr  <= '0;
      pio_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            g_q       <= gidx;
            write_q   <= req_write[gidx];
            pio_addr  <= req_addr[gidx*PIO_AW +: PIO_AW];
            pio_wdata <= req_wdata[gidx*PIO_DW +: PIO_DW];
          end
        end
        ST_ISSUE: begin
          if (!write_q) cnt <= LAT_M1;
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
        end
        ST_RESP: begin
          ptr <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
        end
        default: ;
      endcase
      if (capture) rsp_rdata <= pio_rdata;
    end
  end

`ifdef KIWI_PIO_ARB_STATS_EN
  // x & (x-1) is non-zero exactly when two or more bits are set.
  logic multi_req;
  assign multi_req = (req_valid & (req_valid - NREQ'(1))) != '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_txns      <= '0;
      stat_conflicts <= '0;
    end else begin
      if (state == ST_RESP) stat_txns <= stat_txns + STAT_TXN_W'(1);
      if (state == ST_IDLE && multi_req && stat_conflicts != '1)
        stat_conflicts <= stat_conflicts + STAT_CONF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_kiwi_pio_arbiter.sv
// Scoreboard bench for kiwi_pio_arbiter (NREQ=4, RD_LAT=3).
// Stimulus pushes expected transactions in expected grant order; a monitor
// thread pops them on accept and checks issue, write strobe and response.
module tb_kiwi_pio_arbiter;

  localparam int TB_NREQ = 4;
  localparam int TB_LAT  = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [TB_NREQ-1:0]     req_valid, req_write, req_ready, rsp_valid;
  logic [TB_NREQ*8-1:0]   req_addr;
  logic [TB_NREQ*32-1:0]  req_wdata;
  logic [31:0]            rsp_rdata, pio_wdata, pio_rdata;
  logic [7:0]             pio_addr;
  logic                   pio_hwen;
`ifdef KIWI_PIO_ARB_STATS_EN
  logic [31:0]            stat_txns;
  logic [15:0]            stat_conflicts;
`endif

  kiwi_pio_arbiter #(
    .NREQ   (TB_NREQ),
    .RD_LAT (TB_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .pio_addr  (pio_addr),
    .pio_wdata (pio_wdata),
    .pio_hwen  (pio_hwen),
    .pio_rdata (pio_rdata)
`ifdef KIWI_PIO_ARB_STATS_EN
    ,
    .stat_txns      (stat_txns),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shim model: data for an address appears TB_LAT cycles after it is presented.
  logic [7:0] sp0 = '0, sp1 = '0;
  always @(posedge clk) begin
    sp0 <= pio_addr;
    sp1 <= sp0;
  end
  assign pio_rdata = (sp1 == 8'h04) ? 32'h12345678 : {24'hC0DE00, sp1};

  typedef struct {
    int          idx;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  bit          busy = 0;
  int          acc_cyc = 0;
  int          hw_cnt = 0;
  logic [31:0] last_rd = '0;
  int          rem[TB_NREQ];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (req_ready != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_accept", 32'(req_ready), 32'h0);
          end else begin
            cur = exp_q.pop_front();
            chk("grant_onehot", 32'(req_ready), 32'(1) << cur.idx);
            busy    = 1;
            acc_cyc = cyc;
            hw_cnt  = 0;
          end
        end
        if (busy && cyc == acc_cyc + 1) chk("issue_addr", 32'(pio_addr), 32'(cur.addr));
        if (pio_hwen) begin
          hw_cnt++;
          chk("hwen_on_write", 32'(busy && cur.wr), 32'h1);
          chk("hwen_cycle", cyc - acc_cyc, 32'h1);
          chk("hwen_wdata", pio_wdata, cur.wdata);
        end
        if (rsp_valid != '0) begin
          if (!busy) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
          end else begin
            chk("rsp_onehot", 32'(rsp_valid), 32'(1) << cur.idx);
            chk("rsp_latency", cyc - acc_cyc, cur.wr ? 32'd2 : 32'(1 + TB_LAT));
            chk("rsp_rdata", rsp_rdata, cur.wr ? last_rd : cur.rdata);
            if (cur.wr) chk("hwen_count", hw_cnt, 32'h1);
            else        last_rd = cur.rdata;
            busy = 0;
          end
        end
        if (busy && cyc > acc_cyc + TB_LAT + 6) begin
          chk("rsp_timeout", 32'h0, 32'h1);
          busy = 0;
        end
      end
    end
  endtask

  task automatic expect_txn(input int idx, input bit wr, input logic [7:0] a,
                            input logic [31:0] wd, input logic [31:0] rd);
    txn_t t;
    t.idx = idx; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  task automatic start(input int idx, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, input int n);
    req_write[idx]        = wr;
    req_addr[idx*8 +: 8]  = a;
    req_wdata[idx*32 +: 32] = wd;
    rem[idx]              = n;
    req_valid[idx]        = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < TB_NREQ; i++)
      if (req_valid[i] && req_ready[i] && rem[i] > 0) rem[i]--;
    @(posedge clk);
    #1;
    for (int i = 0; i < TB_NREQ; i++) req_valid[i] = (rem[i] != 0);
  endtask

  function automatic bit pending();
    bit p = busy || (exp_q.size() != 0);
    for (int i = 0; i < TB_NREQ; i++) if (rem[i] != 0) p = 1;
    return p;
  endfunction

  task automatic run(input string name, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(n < budget), 32'h1);
  endtask

`ifdef KIWI_PIO_ARB_STATS_EN
  logic [31:0] txn0;
  logic [15:0] conf0;
`endif

  initial begin
    int n;
    reset_n   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < TB_NREQ; i++) rem[i] = 0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_pio_addr", 32'(pio_addr), 32'h0);
    chk("reset_pio_wdata", pio_wdata, 32'h0);
    chk("reset_pio_hwen", 32'(pio_hwen), 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single write; ptr 0 -> 1
    expect_txn(0, 1, 8'h10, 32'hDEADBEEF, 32'h0);
    start(0, 1, 8'h10, 32'hDEADBEEF, 1);
    run("write_done", 20);

    // single read on req1; ptr 1 -> 2
    expect_txn(1, 0, 8'h04, 32'h0, 32'h12345678);
    start(1, 0, 8'h04, 32'h0, 1);
    run("read_done", 20);

    // fairness from ptr 2: 0,1,0,1; ptr ends at 2
`ifdef KIWI_PIO_ARB_STATS_EN
    txn0 = stat_txns; conf0 = stat_conflicts;
`endif
    expect_txn(0, 0, 8'h20, 32'h0, 32'hC0DE0020);
    expect_txn(1, 0, 8'h24, 32'h0, 32'hC0DE0024);
    expect_txn(0, 0, 8'h20, 32'h0, 32'hC0DE0020);
    expect_txn(1, 0, 8'h24, 32'h0, 32'hC0DE0024);
    start(0, 0, 8'h20, 32'h0, 2);
    start(1, 0, 8'h24, 32'h0, 2);
    run("fair_done", 60);
`ifdef KIWI_PIO_ARB_STATS_EN
    chk("stat_txns_delta", stat_txns - txn0, 32'd4);
    chk("stat_conflicts_delta", 32'(stat_conflicts - conf0), 32'd3);
`endif

    // req2 read moves ptr to 3, then wrap: 3 then 0; ptr ends at 1
    expect_txn(2, 0, 8'h28, 32'h0, 32'hC0DE0028);
    start(2, 0, 8'h28, 32'h0, 1);
    run("ptr3_done", 20);
    expect_txn(3, 0, 8'h30, 32'h0, 32'hC0DE0030);
    expect_txn(0, 1, 8'h00, 32'h0BADF00D, 32'h0);
    start(3, 0, 8'h30, 32'h0, 1);
    start(0, 1, 8'h00, 32'h0BADF00D, 1);
    run("wrap_done", 30);

    // withdraw: req1 pulses during req0's ISSUE and must be ignored; ptr -> 1
    expect_txn(0, 0, 8'h40, 32'h0, 32'hC0DE0040);
    start(0, 0, 8'h40, 32'h0, 1);
    n = 0;
    while (rem[0] != 0 && n < 20) begin step(); n++; end
    req_write[1] = 1'b0;
    req_addr[15:8] = 8'h44;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    run("withdraw_done", 20);

    // reset during WAIT of a req1 read
    expect_txn(1, 0, 8'h08, 32'h0, 32'hC0DE0008);
    start(1, 0, 8'h08, 32'h0, 1);
    n = 0;
    while (rem[1] != 0 && n < 20) begin step(); n++; end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    busy    = 0;
    last_rd = '0;
    req_valid = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_pio_addr", 32'(pio_addr), 32'h0);
    chk("rst_pio_wdata", pio_wdata, 32'h0);
    chk("rst_pio_hwen", 32'(pio_hwen), 32'h0);
`ifdef KIWI_PIO_ARB_STATS_EN
    chk("rst_stat_txns", stat_txns, 32'h0);
    chk("rst_stat_conflicts", 32'(stat_conflicts), 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ptr back at 0: req0 first even though req1 was next before reset
    expect_txn(0, 1, 8'h50, 32'hA5A5A5A5, 32'h0);
    expect_txn(1, 0, 8'h0C, 32'h0, 32'hC0DE000C);
    start(0, 1, 8'h50, 32'hA5A5A5A5, 1);
    start(1, 0, 8'h0C, 32'h0, 1);
    run("post_reset_done", 30);
`ifdef KIWI_PIO_ARB_STATS_EN
    chk("post_reset_stat_txns", stat_txns, 32'd2);
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
